// File: rtl/wb_control_pipe_pkg.sv
// Shared RV32I opcode/funct3 codes, writeback selector codes and the pipeline stage record.
package wb_control_pipe_pkg;

    localparam int unsigned INST_W    = 32;
    localparam int unsigned REG_IDX_W = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] REG_RES       = 2'd0;
    localparam logic [1:0] REG_PC_PLUS_4 = 2'd1;
    localparam logic [1:0] REG_MEM       = 2'd2;

    localparam logic [2:0] LOAD_W  = 3'd0;
    localparam logic [2:0] LOAD_H  = 3'd1;
    localparam logic [2:0] LOAD_HU = 3'd2;
    localparam logic [2:0] LOAD_B  = 3'd3;
    localparam logic [2:0] LOAD_BU = 3'd4;

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [REG_IDX_W-1:0] rd;
        logic [1:0]           reg_sel;
        logic [2:0]           load_sel;
        logic                 is_load;
    } stage_t;

    localparam stage_t STAGE_RESET = '{
        valid:    1'b0,
        we:       1'b0,
        rd:       5'd0,
        reg_sel:  REG_RES,
        load_sel: LOAD_W,
        is_load:  1'b0
    };

endpackage

// File: rtl/wb_decode.sv
// Combinational writeback-control decode of one RV32I instruction word.
module wb_decode
    import wb_control_pipe_pkg::*;
(
    input  logic [INST_W-1:0] inst_i,
    output logic              we_o,
    output logic [1:0]        reg_sel_o,
    output logic [2:0]        load_sel_o,
    output logic              is_load_o
);

    logic unused_bits;
    assign unused_bits = ^{inst_i[31:15], inst_i[11:7]};

    always_comb begin
        we_o       = 1'b0;
        reg_sel_o  = REG_RES;
        load_sel_o = LOAD_W;
        is_load_o  = 1'b0;
        case (inst_i[6:0])
            OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC: begin
                we_o = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                we_o      = 1'b1;
                reg_sel_o = REG_PC_PLUS_4;
            end
            OPC_LOAD: begin
                we_o      = 1'b1;
                reg_sel_o = REG_MEM;
                is_load_o = 1'b1;
                // Reserved load widths fall back to a full-word extract.
                case (inst_i[14:12])
                    F3_LW:   load_sel_o = LOAD_W;
                    F3_LH:   load_sel_o = LOAD_H;
                    F3_LHU:  load_sel_o = LOAD_HU;
                    F3_LB:   load_sel_o = LOAD_B;
                    F3_LBU:  load_sel_o = LOAD_BU;
                    default: load_sel_o = LOAD_W;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_control_pipe.sv
// Writeback control pipeline: decoded write info travels DEPTH stages, with hazard lookup and retire count.
module wb_control_pipe
    import wb_control_pipe_pkg::*;
#(
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           inst_valid,
    input  logic [INST_W-1:0]              inst,
    input  logic                           stall,
    input  logic                           flush,
    input  logic [REG_IDX_W*NUM_SRC-1:0]   src,
    output logic [REG_IDX_W-1:0]           rd,
    output logic                           reg_we,
    output logic [1:0]                     reg_sel,
    output logic [2:0]                     load_sel,
    output logic [NUM_SRC-1:0]             hit,
    output logic [NUM_SRC-1:0]             load_hit,
    output logic [CNT_W-1:0]               retired
);

    stage_t            stage_q [DEPTH];
    stage_t            stage_d [DEPTH];
    stage_t            cap;
    logic [CNT_W-1:0]  retired_q;

    logic              dec_we;
    logic [1:0]        dec_reg_sel;
    logic [2:0]        dec_load_sel;
    logic              dec_is_load;

    wb_decode u_decode (
        .inst_i     (inst),
        .we_o       (dec_we),
        .reg_sel_o  (dec_reg_sel),
        .load_sel_o (dec_load_sel),
        .is_load_o  (dec_is_load)
    );

    // Capture record; writes to x0 are dropped here so no later logic needs to care.
    always_comb begin
        cap          = STAGE_RESET;
        cap.valid    = inst_valid;
        cap.rd       = inst[11:7];
        cap.we       = dec_we & (inst[11:7] != 5'd0);
        cap.reg_sel  = dec_reg_sel;
        cap.load_sel = dec_load_sel;
        cap.is_load  = dec_is_load;
    end

    // Shift or hold, then kill every stage but the oldest on flush.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (!stall) begin
            stage_d[0] = cap;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
        if (flush) begin
            for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
                stage_d[k].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= STAGE_RESET;
            end
            retired_q <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
            if (reg_we) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Stall gates the write so a held instruction commits exactly once.
    assign reg_we   = stage_q[DEPTH-1].valid & stage_q[DEPTH-1].we & ~stall;
    assign rd       = stage_q[DEPTH-1].rd;
    assign reg_sel  = stage_q[DEPTH-1].reg_sel;
    assign load_sel = stage_q[DEPTH-1].load_sel;
    assign retired  = retired_q;

    // Scan oldest to youngest so the youngest match decides load_hit.
    always_comb begin
        hit      = '0;
        load_hit = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned k = DEPTH; k > 0; k--) begin
                if ((src[REG_IDX_W*i +: REG_IDX_W] != 5'd0) && stage_q[k-1].valid &&
                    stage_q[k-1].we && (stage_q[k-1].rd == src[REG_IDX_W*i +: REG_IDX_W])) begin
                    hit[i]      = 1'b1;
                    load_hit[i] = stage_q[k-1].is_load;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_control_pipe.sv
// Bench for wb_control_pipe: instruction-level reference model checked every cycle plus directed literal checks.
module tb_wb_control_pipe;
    import wb_control_pipe_pkg::*;

    localparam int unsigned DEPTH = 3;
    localparam int unsigned NSRC  = 2;
    localparam int unsigned CW    = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clock = 1'b0;
    logic             reset;
    logic             inst_valid;
    logic [31:0]      inst;
    logic             stall;
    logic             flush;
    logic [5*NSRC-1:0] src;
    logic [4:0]       rd;
    logic             reg_we;
    logic [1:0]       reg_sel;
    logic [2:0]       load_sel;
    logic [NSRC-1:0]  hit;
    logic [NSRC-1:0]  load_hit;
    logic [CW-1:0]    retired;

    int total = 0;
    int bad   = 0;

    wb_control_pipe #(.DEPTH(DEPTH), .NUM_SRC(NSRC), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .inst_valid (inst_valid),
        .inst       (inst),
        .stall      (stall),
        .flush      (flush),
        .src        (src),
        .rd         (rd),
        .reg_we     (reg_we),
        .reg_sel    (reg_sel),
        .load_sel   (load_sel),
        .hit        (hit),
        .load_hit   (load_hit),
        .retired    (retired)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of an instruction word for writeback purposes.
    function automatic void mdec(input logic [31:0] w, output bit we, output logic [1:0] sel,
                                 output logic [2:0] ls, output bit ld);
        we = 1'b0; sel = REG_RES; ls = LOAD_W; ld = 1'b0;
        case (w[6:0])
            7'h13, 7'h33, 7'h37, 7'h17: we = 1'b1;
            7'h6f, 7'h67: begin we = 1'b1; sel = REG_PC_PLUS_4; end
            7'h03: begin
                we = 1'b1; sel = REG_MEM; ld = 1'b1;
                case (w[14:12])
                    3'b001:  ls = LOAD_H;
                    3'b101:  ls = LOAD_HU;
                    3'b000:  ls = LOAD_B;
                    3'b100:  ls = LOAD_BU;
                    default: ls = LOAD_W;
                endcase
            end
            default: ;
        endcase
        if (w[11:7] == 5'd0) we = 1'b0;
    endfunction

    // Model: which instruction words sit where, plus the commit count.
    bit          m_valid [DEPTH];
    logic [31:0] m_inst  [DEPTH];
    logic [CW-1:0] m_ret;

    always @(negedge clock) begin : cmp
        bit          we_k;
        logic [1:0]  sel_k;
        logic [2:0]  ls_k;
        bit          ld_k;
        logic [4:0]  s;
        logic [NSRC-1:0] eh;
        logic [NSRC-1:0] elh;
        if (!reset) begin
            chk("rst_reg_we", 32'(reg_we), 32'd0);
            chk("rst_rd", 32'(rd), 32'd0);
            chk("rst_reg_sel", 32'(reg_sel), 32'(REG_RES));
            chk("rst_load_sel", 32'(load_sel), 32'(LOAD_W));
            chk("rst_hit", 32'(hit), 32'd0);
            chk("rst_load_hit", 32'(load_hit), 32'd0);
            chk("rst_retired", 32'(retired), 32'd0);
            for (int k = 0; k < DEPTH; k++) begin
                m_valid[k] = 1'b0;
                m_inst[k]  = NOP;
            end
            m_ret = '0;
        end else begin
            mdec(m_inst[DEPTH-1], we_k, sel_k, ls_k, ld_k);
            chk("reg_we", 32'(reg_we), 32'(m_valid[DEPTH-1] && we_k && !stall));
            chk("rd", 32'(rd), 32'(m_inst[DEPTH-1][11:7]));
            chk("reg_sel", 32'(reg_sel), 32'(sel_k));
            chk("load_sel", 32'(load_sel), 32'(ls_k));
            chk("retired", 32'(retired), 32'(m_ret));
            eh = '0; elh = '0;
            for (int i = 0; i < NSRC; i++) begin
                s = src[5*i +: 5];
                for (int k = 0; k < DEPTH; k++) begin
                    mdec(m_inst[k], we_k, sel_k, ls_k, ld_k);
                    if (!eh[i] && s != 5'd0 && m_valid[k] && we_k && m_inst[k][11:7] == s) begin
                        eh[i]  = 1'b1;
                        elh[i] = ld_k;
                    end
                end
            end
            chk("hit", 32'(hit), 32'(eh));
            chk("load_hit", 32'(load_hit), 32'(elh));
            // Advance the model for the coming edge; inputs are stable until after it.
            mdec(m_inst[DEPTH-1], we_k, sel_k, ls_k, ld_k);
            if (m_valid[DEPTH-1] && we_k && !stall) m_ret = m_ret + CW'(1);
            if (!stall) begin
                for (int k = DEPTH-1; k > 0; k--) begin
                    m_valid[k] = m_valid[k-1];
                    m_inst[k]  = m_inst[k-1];
                end
                m_valid[0] = inst_valid;
                m_inst[0]  = inst;
            end
            if (flush) begin
                for (int k = 0; k < DEPTH-1; k++) m_valid[k] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] w);
        inst_valid = 1'b1;
        inst       = w;
        tick();
        inst_valid = 1'b0;
        inst       = NOP;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; inst_valid = 1'b0; inst = NOP; stall = 1'b0; flush = 1'b0; src = '0;
        repeat (3) tick();
        chk("a_rst_we", 32'(reg_we), 32'd0);
        chk("a_rst_ret", 32'(retired), 32'd0);
        reset = 1'b1;

        // ADDI x5 reaches writeback three edges after it is presented.
        issue(32'h0050_0293);
        tick();
        chk("a_we_early", 32'(reg_we), 32'd0);
        tick();
        chk("a_we", 32'(reg_we), 32'd1);
        chk("a_rd", 32'(rd), 32'd5);
        chk("a_sel", 32'(reg_sel), 32'(REG_RES));
        tick();
        chk("a_ret", 32'(retired), 32'd1);
        chk("a_we_after", 32'(reg_we), 32'd0);

        // LH x7 held at writeback for two cycles.
        issue(32'h0000_1383);
        tick();
        tick();
        stall = 1'b1;
        #1;
        chk("b_we_stall0", 32'(reg_we), 32'd0);
        chk("b_load_sel", 32'(load_sel), 32'(LOAD_H));
        tick();
        chk("b_we_stall1", 32'(reg_we), 32'd0);
        tick();
        stall = 1'b0;
        #1;
        chk("b_we_release", 32'(reg_we), 32'd1);
        chk("b_rd", 32'(rd), 32'd7);
        tick();
        chk("b_we_once", 32'(reg_we), 32'd0);
        chk("b_ret", 32'(retired), 32'd2);

        // ADDI x0 and a store never write.
        src = {5'd0, 5'd8};
        issue(32'h0000_0013);
        issue(32'h0050_2423);
        chk("c_hit", 32'(hit), 32'd0);
        repeat (3) tick();
        chk("c_ret", 32'(retired), 32'd2);

        // ADD x9 older, LW x9 younger: load wins the lookup.
        src = {5'd10, 5'd9};
        issue(32'h0000_04B3);
        issue(32'h0000_2483);
        chk("d_hit", 32'(hit), 32'b01);
        chk("d_load_hit", 32'(load_hit), 32'b01);
        repeat (3) tick();
        chk("d_ret", 32'(retired), 32'd4);
        src = '0;

        // Flush under stall keeps only the oldest write.
        issue(32'h0000_0093);
        issue(32'h0000_0113);
        issue(32'h0000_0193);
        stall = 1'b1; flush = 1'b1;
        #1;
        chk("e_we_stall", 32'(reg_we), 32'd0);
        tick();
        flush = 1'b0;
        tick();
        stall = 1'b0;
        #1;
        chk("e_we", 32'(reg_we), 32'd1);
        chk("e_rd", 32'(rd), 32'd1);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("e_no_young", 32'(reg_we), 32'd0);
        end
        chk("e_ret", 32'(retired), 32'd5);

        // Flush without stall: oldest advances, capture discarded.
        issue(32'h0000_0093);
        issue(32'h0000_0113);
        flush = 1'b1; inst_valid = 1'b1; inst = 32'h0000_0193;
        tick();
        flush = 1'b0; inst_valid = 1'b0; inst = NOP;
        chk("f_we", 32'(reg_we), 32'd1);
        chk("f_rd", 32'(rd), 32'd1);
        repeat (3) tick();
        chk("f_ret", 32'(retired), 32'd6);

        // Decode mix, including a reserved load width and a bubble carrying a writer.
        src = {5'd12, 5'd11};
        issue(32'h0000_00EF);
        issue(32'h0000_0337);
        issue(32'h0000_0397);
        inst = 32'h0000_0213;
        tick();
        inst = NOP;
        issue(32'h0000_0467);
        issue(32'h0000_3503);
        issue(32'h0000_4583);
        issue(32'h0000_5603);
        issue(32'h0000_0683);
        issue(32'h0000_0063);
        repeat (4) tick();
        chk("g_ret", 32'(retired), 32'd14);
        src = '0;

        // Counter wraps at 2^CW.
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        for (int k = 1; k <= 17; k++) issue((32'(k) << 7) | 32'h13);
        repeat (3) tick();
        chk("h_ret_wrap", 32'(retired), 32'd1);

        // Reset mid-stream discards everything in flight.
        src = {5'd0, 5'd4};
        issue(32'h0000_0213);
        issue(32'h0000_0213);
        issue(32'h0000_0213);
        reset = 1'b0;
        #1;
        chk("i_we", 32'(reg_we), 32'd0);
        chk("i_rd", 32'(rd), 32'd0);
        chk("i_hit", 32'(hit), 32'd0);
        chk("i_ret", 32'(retired), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("i_no_write", 32'(reg_we), 32'd0);
        end
        chk("i_ret_end", 32'(retired), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
